// File: rtl/click_decoder.sv
// Single/double click classifier: synchronises a debounced press pulse, detects its rising
// edge and decides whether a second press follows within WINDOW cycles.
module click_decoder #(
    parameter int unsigned WINDOW = 15000000
) (
    input  logic       clk_50MHZ,
    input  logic       reset,
    input  logic       btn_in,
    output logic       single_click,
    output logic       double_click,
    output logic       pending,
    output logic [7:0] press_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    localparam logic [23:0] TIMER_LAST = 24'(WINDOW - 1);

    state_t      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic        single_q, single_d;
    logic        double_q, double_d;
    logic        pending_q, pending_d;
    logic [7:0]  count_q, count_d;
    logic        rise;

    // s1/s2 resolve metastability; s3 is only history for the edge detect
    assign rise = s2_q & ~s3_q;

    always_comb begin
        s1_d      = btn_in;
        s2_d      = s1_q;
        s3_d      = s2_q;
        state_d   = state_q;
        timer_d   = timer_q;
        single_d  = 1'b0;
        double_d  = 1'b0;
        pending_d = pending_q;
        count_d   = count_q + {7'd0, rise};

        unique case (state_q)
            IDLE: begin
                timer_d = 24'd0;
                if (rise) begin
                    state_d   = WAIT2;
                    pending_d = 1'b1;
                end
            end
            WAIT2: begin
                // A rise on the final timer cycle still counts as the second press
                if (rise) begin
                    state_d   = IDLE;
                    timer_d   = 24'd0;
                    double_d  = 1'b1;
                    pending_d = 1'b0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = IDLE;
                    timer_d   = 24'd0;
                    single_d  = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                timer_d   = 24'd0;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50MHZ) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= 24'd0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            single_q  <= single_d;
            double_q  <= double_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign pending      = pending_q;
    assign press_count  = count_q;

endmodule

// File: tb/tb_click_decoder.sv
// Bench for click_decoder (WINDOW=20): directed presses push expected click events
// {cycle, kind, press_count} into a queue; a monitor pops and compares each click pulse.
module tb_click_decoder;

    localparam int WIN = 20;
    localparam int W   = 26;
    localparam logic [1:0] K_SINGLE = 2'b01;
    localparam logic [1:0] K_DOUBLE = 2'b10;

    logic       clk_50MHZ = 1'b0;
    logic       reset     = 1'b0;
    logic       btn_in    = 1'b0;
    logic       single_click;
    logic       double_click;
    logic       pending;
    logic [7:0] press_count;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int singles_seen = 0;

    click_decoder #(.WINDOW(WIN)) dut (
        .clk_50MHZ    (clk_50MHZ),
        .reset        (reset),
        .btn_in       (btn_in),
        .single_click (single_click),
        .double_click (double_click),
        .pending      (pending),
        .press_count  (press_count)
    );

    // clock / cycle counter: cyc equals the number of rising edges seen so far
    always #10 clk_50MHZ = ~clk_50MHZ;
    always @(posedge clk_50MHZ) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, exp);
        end
    endtask

    task automatic push(input int at_cycle, input logic [1:0] kind, input int cnt);
        exp_q.push_back({16'(at_cycle), kind, 8'(cnt)});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk_50MHZ);
    endtask

    task automatic reset_dut();
        @(negedge clk_50MHZ);
        reset  = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(negedge clk_50MHZ);
        reset = 1'b0;
    endtask

    // monitor: every click pulse must match the head of the expected queue
    always @(negedge clk_50MHZ) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (single_click && double_click) begin
            n_cmp++;
            n_err++;
            $display("FAIL both_clicks at cycle %0d: got single=1 double=1, required at most one", cyc);
        end else if (single_click || double_click) begin
            if (single_click) singles_seen++;
            got = {16'(cyc), double_click, single_click, press_count};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_click at cycle %0d: got kind=%b count=%0d, required none",
                         cyc, got[9:8], got[7:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL click_event: got cycle=%0d kind=%b count=%0d, required cycle=%0d kind=%b count=%0d",
                             got[25:10], got[9:8], got[7:0], exp[25:10], exp[9:8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        int c1;
        int c2;
        int s0;

        // reset state
        reset_dut();
        check("reset_pending", int'(pending), 0);
        check("reset_count", int'(press_count), 0);
        check("reset_single", int'(single_click), 0);
        check("reset_double", int'(double_click), 0);

        // single press held 50 cycles: one rise, single_click 20 cycles after pending
        @(negedge clk_50MHZ);
        btn_in = 1'b1;
        c1 = cyc;
        push(c1 + 3 + WIN, K_SINGLE, 1);
        wait_until(c1 + 2);
        check("single_pending_early", int'(pending), 0);
        wait_until(c1 + 3);
        check("single_pending_set", int'(pending), 1);
        check("single_count", int'(press_count), 1);
        wait_until(c1 + 2 + WIN);
        check("single_pending_hold", int'(pending), 1);
        wait_until(c1 + 3 + WIN);
        check("single_pending_clear", int'(pending), 0);
        wait_until(c1 + 50);
        btn_in = 1'b0;
        wait_until(c1 + 80);
        check("single_count_final", int'(press_count), 1);

        // double press: 5-cycle pulses with rises 10 cycles apart
        reset_dut();
        btn_in = 1'b1;
        c1 = cyc;
        wait_until(c1 + 5);
        btn_in = 1'b0;
        wait_until(c1 + 10);
        btn_in = 1'b1;
        c2 = cyc;
        push(c2 + 3, K_DOUBLE, 2);
        wait_until(c2 + 3);
        check("double_pending", int'(pending), 0);
        check("double_count", int'(press_count), 2);
        wait_until(c2 + 5);
        btn_in = 1'b0;
        wait_until(c2 + 40);

        // second rise detected in the timer==WINDOW-1 cycle: double only
        reset_dut();
        btn_in = 1'b1;
        c1 = cyc;
        wait_until(c1 + 3);
        btn_in = 1'b0;
        wait_until(c1 + WIN);
        btn_in = 1'b1;
        c2 = cyc;
        push(c2 + 3, K_DOUBLE, 2);
        wait_until(c2 + 3);
        btn_in = 1'b0;
        check("edge_double_pending", int'(pending), 0);
        wait_until(c2 + 40);
        check("edge_double_count", int'(press_count), 2);

        // second rise one cycle too late: single, then a fresh WAIT2 and single
        reset_dut();
        btn_in = 1'b1;
        c1 = cyc;
        push(c1 + 3 + WIN, K_SINGLE, 1);
        wait_until(c1 + 3);
        btn_in = 1'b0;
        wait_until(c1 + WIN + 1);
        btn_in = 1'b1;
        c2 = cyc;
        push(c2 + 3 + WIN, K_SINGLE, 2);
        wait_until(c2 + 3);
        btn_in = 1'b0;
        check("late_rearm_pending", int'(pending), 1);
        wait_until(c2 + 40);
        check("late_count", int'(press_count), 2);

        // reset pulsed during WAIT2 at timer=8 abandons the sequence
        reset_dut();
        btn_in = 1'b1;
        c1 = cyc;
        wait_until(c1 + 5);
        btn_in = 1'b0;
        wait_until(c1 + 11);
        reset = 1'b1;
        wait_until(c1 + 12);
        reset = 1'b0;
        check("midreset_pending", int'(pending), 0);
        check("midreset_count", int'(press_count), 0);
        wait_until(c1 + 50);
        btn_in = 1'b1;
        c2 = cyc;
        push(c2 + 3 + WIN, K_SINGLE, 1);
        wait_until(c2 + 5);
        btn_in = 1'b0;
        wait_until(c2 + 40);

        // btn held high through reset release is one rise two cycles later
        @(negedge clk_50MHZ);
        reset  = 1'b1;
        btn_in = 1'b1;
        repeat (3) @(negedge clk_50MHZ);
        reset = 1'b0;
        c1 = cyc;
        push(c1 + 3 + WIN, K_SINGLE, 1);
        wait_until(c1 + 2);
        check("held_reset_pending_early", int'(pending), 0);
        wait_until(c1 + 3);
        check("held_reset_pending", int'(pending), 1);
        wait_until(c1 + 30);
        btn_in = 1'b0;
        wait_until(c1 + 40);

        // 256 isolated presses wrap press_count back to 0
        reset_dut();
        s0 = singles_seen;
        for (int k = 0; k < 256; k++) begin
            btn_in = 1'b1;
            c1 = cyc;
            push(c1 + 3 + WIN, K_SINGLE, (k + 1) % 256);
            wait_until(c1 + 2);
            btn_in = 1'b0;
            wait_until(c1 + 26);
        end
        check("wrap_count", int'(press_count), 0);
        check("wrap_singles", singles_seen - s0, 256);

        // drain: every expected click must have appeared
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_50MHZ);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
